serdes_clk_gen: RTL and testbench

//  Parametrised word/bit timing generator for the iCE40UP serializer datapath.
//  - Runs on the bit clock and produces word-rate clock, LOAD and word-start strobes, a DDR clock and a slot index.
//  - Generalises the fixed divide-by-8 generator: runtime divide ratio, phase resync, lock status and error flag.
//  - Single clock domain: everything is registered on the CLKIN rising edge; no falling-edge logic.

---
 rtl/serdes_clk_gen_if.sv | 25 ++
 rtl/serdes_clk_gen.sv | 140 ++++++++++++++
 tb/tb_serdes_clk_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/serdes_clk_gen_if.sv
// Control and timing-output bundle of the serializer word/bit timing generator.
interface serdes_clk_gen_if #(
  parameter int unsigned DIV_W = 4
);
  logic             en;
  logic             resync;
  logic [DIV_W-1:0] div;
  logic             byte_clk;
  logic             load;
  logic             word_st;
  logic             ddr_clk;
  logic [DIV_W-1:0] bit_idx;
  logic             locked;
  logic             div_err;

  modport master (
    output en, resync, div,
    input  byte_clk, load, word_st, ddr_clk, bit_idx, locked, div_err
  );

  modport slave (
    input  en, resync, div,
    output byte_clk, load, word_st, ddr_clk, bit_idx, locked, div_err
  );
endinterface

// File: rtl/serdes_clk_gen.sv
// Word/bit timing generator on the bit clock: word clock, LOAD/word-start strobes,
// DDR clock, slot index, lock status and divide-ratio error, all registered.
module serdes_clk_gen #(
  parameter int unsigned DIV_W      = 4,
  parameter int unsigned LOCK_WORDS = 4
) (
  input  logic              clkin,
  input  logic              resetn,
  serdes_clk_gen_if.slave   bus
);

  localparam int unsigned      WC_W    = $clog2(LOCK_WORDS + 1);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [WC_W-1:0]  WC_MAX  = WC_W'(LOCK_WORDS);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t           state_q, state_d;
  logic             en_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic             div_err_q, div_err_d;
  logic             byte_clk_q, byte_clk_d;
  logic             load_q, load_d;
  logic             word_st_q, word_st_d;
  logic             ddr_q, ddr_d;
  logic             locked_q, locked_d;
  logic             div_legal_c;
  logic             last_c;
  logic [DIV_W:0]   half_c;

  // State, counters and registered outputs
  always_ff @(posedge clkin) begin
    if (!resetn) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      div_q      <= DIV_MIN;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      div_err_q  <= 1'b0;
      byte_clk_q <= 1'b0;
      load_q     <= 1'b0;
      word_st_q  <= 1'b0;
      ddr_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= bus.en;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      div_err_q  <= div_err_d;
      byte_clk_q <= byte_clk_d;
      load_q     <= load_d;
      word_st_q  <= word_st_d;
      ddr_q      <= ddr_d;
      locked_q   <= locked_d;
    end
  end

  // Next state; outputs are decoded from the next slot so they align with cnt.
  // Start needs EN on two consecutive edges, giving the two-cycle start latency.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = '0;
    wcnt_d      = wcnt_q;
    div_err_d   = div_err_q;
    byte_clk_d  = 1'b0;
    load_d      = 1'b0;
    word_st_d   = 1'b0;
    ddr_d       = 1'b0;
    locked_d    = 1'b0;
    div_legal_c = (bus.div >= DIV_MIN);
    last_c      = (cnt_q == div_q - DIV_W'(1));

    case (state_q)
      IDLE: begin
        wcnt_d = '0;
        if (bus.en && en_q) state_d = SYNC;
      end
      SYNC: begin
        wcnt_d = '0;
        if (!bus.en) begin
          state_d = IDLE;
        end else if (div_legal_c) begin
          div_d     = bus.div;
          div_err_d = 1'b0;
          state_d   = RUN;
        end else begin
          div_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      RUN: begin
        if (!bus.en) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (bus.resync) begin
          state_d = SYNC;
          wcnt_d  = '0;
        end else begin
          cnt_d = last_c ? '0 : cnt_q + DIV_W'(1);
          if (last_c) begin
            if (wcnt_q != WC_MAX) wcnt_d = wcnt_q + WC_W'(1);
            if (!div_legal_c) begin
              div_err_d = 1'b1;
            end else begin
              div_err_d = 1'b0;
              if (bus.div != div_q) begin
                div_d  = bus.div;
                wcnt_d = '0;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    half_c = ({1'b0, div_d} + (DIV_W+1)'(1)) >> 1;
    if (state_d == RUN) begin
      byte_clk_d = ({1'b0, cnt_d} < half_c);
      load_d     = (cnt_d == div_d - DIV_W'(1));
      word_st_d  = (cnt_d == '0);
      ddr_d      = (cnt_d != '0) && !ddr_q;
      locked_d   = (wcnt_d == WC_MAX);
    end
  end

  assign bus.byte_clk = byte_clk_q;
  assign bus.load     = load_q;
  assign bus.word_st  = word_st_q;
  assign bus.ddr_clk  = ddr_q;
  assign bus.bit_idx  = cnt_q;
  assign bus.locked   = locked_q;
  assign bus.div_err  = div_err_q;

endmodule

// File: tb/tb_serdes_clk_gen.sv
// Directed bench for serdes_clk_gen: slot patterns, divide changes, lock, errors,
// resync, enable abort and reset, against a small per-slot expectation function.
module tb_serdes_clk_gen;

  localparam int unsigned DIV_W      = 4;
  localparam int unsigned LOCK_WORDS = 4;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  serdes_clk_gen_if #(.DIV_W(DIV_W)) bus ();

  serdes_clk_gen #(.DIV_W(DIV_W), .LOCK_WORDS(LOCK_WORDS)) dut (
    .clkin  (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {bit_idx, byte_clk, load, word_st, ddr_clk}
  function automatic logic [7:0] got_pack();
    return {bus.bit_idx, bus.byte_clk, bus.load, bus.word_st, bus.ddr_clk};
  endfunction

  function automatic logic [7:0] exp_pack(input int s, input int d);
    logic [3:0] idx;
    idx = 4'(s);
    return {idx, 1'(s < (d + 1) / 2), 1'(s == d - 1), 1'(s == 0), 1'(s % 2)};
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, " slots"}, 32'(got_pack()), 32'd0);
    check_eq({tag, " locked"}, 32'(bus.locked), 32'd0);
  endtask

  task automatic run_part(input string tag, input int d, input int s0, input int s1, input logic lk);
    for (int s = s0; s <= s1; s++) begin
      tick();
      check_eq($sformatf("%s d%0d s%0d", tag, d, s), 32'(got_pack()), 32'(exp_pack(s, d)));
      check_eq($sformatf("%s d%0d s%0d locked", tag, d, s), 32'(bus.locked), 32'(lk));
    end
  endtask

  task automatic run_words(input string tag, input int d, input int n, input int w0);
    for (int w = 0; w < n; w++)
      run_part($sformatf("%s w%0d", tag, w), d, 0, d - 1, 1'((w0 + w) >= int'(LOCK_WORDS)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn     = 1'b0;
    bus.en     = 1'b0;
    bus.resync = 1'b0;
    bus.div    = 4'd8;
    tick();
    tick();
    check_idle("reset");
    check_eq("reset div_err", 32'(bus.div_err), 32'd0);

    // Divide by 8 from enable, lock after four words
    resetn = 1'b1;
    bus.en = 1'b1;
    tick();
    check_idle("start idle");
    tick();
    check_idle("start sync");
    run_words("div8", 8, 5, 0);

    // Mid-word request 8->4 takes effect at the boundary and drops lock
    run_part("chg8", 8, 0, 2, 1'b1);
    bus.div = 4'd4;
    run_part("chg8", 8, 3, 7, 1'b1);
    run_words("div4", 4, 5, 0);

    // Odd divide
    bus.div = 4'd5;
    run_words("div5", 5, 2, 0);

    // Resync mid-word after lock, then resync coincident with LOAD
    bus.div = 4'd8;
    run_words("rs8", 8, 4, 0);
    run_part("rs8 lk", 8, 0, 3, 1'b1);
    bus.resync = 1'b1;
    tick();
    check_idle("resync mid sync");
    bus.resync = 1'b0;
    run_part("after rs", 8, 0, 7, 1'b0);
    bus.resync = 1'b1;
    tick();
    check_idle("resync load sync");
    bus.resync = 1'b0;
    run_part("after rs load", 8, 0, 2, 1'b0);

    // Enable drop mid-word, then illegal DIV at SYNC loops IDLE/SYNC
    bus.en = 1'b0;
    tick();
    check_idle("en low");
    check_eq("en low div_err", 32'(bus.div_err), 32'd0);
    bus.div = 4'd1;
    bus.en  = 1'b1;
    tick();
    check_idle("bad idle0");
    tick();
    check_idle("bad sync0");
    tick();
    check_idle("bad idle1");
    check_eq("bad div_err1", 32'(bus.div_err), 32'd1);
    tick();
    check_idle("bad sync1");
    check_eq("bad div_err2", 32'(bus.div_err), 32'd1);
    bus.div = 4'd6;
    run_words("div6", 6, 1, 0);
    check_eq("div6 div_err", 32'(bus.div_err), 32'd0);

    // Illegal DIV at a boundary keeps the ratio and flags the error
    bus.div = 4'd0;
    run_part("div0 keep6", 6, 0, 5, 1'b0);
    check_eq("div0 div_err", 32'(bus.div_err), 32'd1);

    // Reset at slot 5 clears everything; release restarts with two-cycle latency
    resetn  = 1'b0;
    bus.div = 4'd8;
    tick();
    check_idle("mid reset");
    check_eq("mid reset div_err", 32'(bus.div_err), 32'd0);
    resetn = 1'b1;
    tick();
    check_idle("rel idle");
    tick();
    check_idle("rel sync");
    run_part("rel", 8, 0, 7, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
